// File: rtl/fetch_hazard_ctrl_if.sv
// Hazard inputs from Decode/Execute and the stall/flush/select controls
// returned to the PC, IF/ID and ID/EX registers.
interface fetch_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             MemReadE;
   logic [4:0]       RdE;
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic             UsesRs1D;
   logic             UsesRs2D;
   logic             PCSrcE;
   logic             JumpE;
   logic             is_jalr_E;
   logic             DivStartE;
   logic [1:0]       PCSelF;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushD;
   logic             FlushE;
   logic             DivBusy;
   logic             DivDoneE;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output MemReadE, RdE, Rs1D, Rs2D, UsesRs1D, UsesRs2D,
             PCSrcE, JumpE, is_jalr_E, DivStartE,
      input  PCSelF, StallF, StallD, StallE, FlushD, FlushE,
             DivBusy, DivDoneE, StallCount, FlushCount
   );

   modport slave (
      input  MemReadE, RdE, Rs1D, Rs2D, UsesRs1D, UsesRs2D,
             PCSrcE, JumpE, is_jalr_E, DivStartE,
      output PCSelF, StallF, StallD, StallE, FlushD, FlushE,
             DivBusy, DivDoneE, StallCount, FlushCount
   );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Front-end sequencing: PC select, stall/flush resolution for redirects,
// load-use hazards and multi-cycle divides, plus saturating event counters.
module fetch_hazard_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   fetch_hazard_ctrl_if.slave  hz
);
   localparam int DCW = 16;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t       state, state_nxt;
   logic [DCW-1:0]   div_cnt, div_cnt_nxt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   logic       redirect, jalr_sel, lw_stall, div_stall;
   logic [1:0] pc_sel;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e;

   assign jalr_sel = hz.JumpE & hz.is_jalr_E;
   assign redirect = hz.PCSrcE | jalr_sel;
   assign lw_stall = hz.MemReadE & (hz.RdE != 5'd0) &
                     ((hz.UsesRs1D & (hz.Rs1D == hz.RdE)) |
                      (hz.UsesRs2D & (hz.Rs2D == hz.RdE)));
   assign div_stall = ((state == IDLE) & hz.DivStartE & ~redirect) | (state == BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         div_cnt <= '0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_cnt_nxt;
      end
   end

   // The counter preload of DIV_CYCLES-2 plus the IDLE start cycle and the
   // terminal zero cycle gives exactly DIV_CYCLES stalled cycles.
   always_comb begin
      state_nxt   = state;
      div_cnt_nxt = div_cnt;
      case (state)
         IDLE: if (hz.DivStartE && !redirect) begin
            state_nxt   = BUSY;
            div_cnt_nxt = DCW'(DIV_CYCLES - 2);
         end
         BUSY: if (div_cnt == '0) state_nxt = DONE;
               else               div_cnt_nxt = div_cnt - 1'b1;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pc_sel  = 2'b00;
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (!rst) begin
         pc_sel = 2'b00;
      end else if (div_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
      end else if (redirect) begin
         pc_sel  = jalr_sel ? 2'b10 : 2'b01;
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign hz.PCSelF     = pc_sel;
   assign hz.StallF     = stall_f;
   assign hz.StallD     = stall_d;
   assign hz.StallE     = stall_e;
   assign hz.FlushD     = flush_d;
   assign hz.FlushE     = flush_e;
   assign hz.DivBusy    = rst & (state != IDLE);
   assign hz.DivDoneE   = rst & (state == DONE);
   assign hz.StallCount = stall_cnt;
   assign hz.FlushCount = flush_cnt;
endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl with DIV_CYCLES=4, CNT_W=4.
module tb_fetch_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   fetch_hazard_ctrl_if #(.CNT_W(4)) hz ();
   fetch_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .hz(hz));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hz.MemReadE = 0; hz.RdE = 0; hz.Rs1D = 0; hz.Rs2D = 0;
      hz.UsesRs1D = 0; hz.UsesRs2D = 0; hz.PCSrcE = 0; hz.JumpE = 0;
      hz.is_jalr_E = 0; hz.DivStartE = 0;
   endtask

   task automatic set_lw();
      hz.MemReadE = 1; hz.RdE = 5'd5; hz.Rs2D = 5'd5; hz.UsesRs2D = 1;
   endtask

   task automatic do_reset();
      #1 rst = 0;
      #1 rst = 1;
      #1;
   endtask

   function automatic logic [31:0] ctl();
      return {24'd0, hz.PCSelF, hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.DivDoneE};
   endfunction

   initial begin
      idle_inputs();
      // Reset with hazards driven: everything must read zero.
      rst = 0;
      hz.PCSrcE = 1; hz.MemReadE = 1; hz.RdE = 5'd5; hz.Rs1D = 5'd5; hz.UsesRs1D = 1;
      hz.DivStartE = 1;
      step(); step();
      chk("rst_ctl", ctl(), 32'h0);
      chk("rst_busy", {31'd0, hz.DivBusy}, 32'd0);
      chk("rst_scnt", {28'd0, hz.StallCount}, 32'd0);
      chk("rst_fcnt", {28'd0, hz.FlushCount}, 32'd0);
      idle_inputs();
      rst = 1;
      step();
      chk("idle_pcsel", {30'd0, hz.PCSelF}, 32'd0);
      chk("idle_ctl", ctl(), 32'h0);
      chk("idle_scnt", {28'd0, hz.StallCount}, 32'd0);
      chk("idle_fcnt", {28'd0, hz.FlushCount}, 32'd0);

      // JALR redirect: PCSel=10, flush both, no stall.
      hz.JumpE = 1; hz.is_jalr_E = 1; hz.PCSrcE = 1;
      #1;
      chk("jalr_ctl", ctl(), {24'd0, 2'b10, 3'b000, 2'b11, 1'b0});
      step(); idle_inputs(); #1;
      chk("jalr_fcnt", {28'd0, hz.FlushCount}, 32'd1);
      // Branch taken: PCSel=01.
      hz.PCSrcE = 1;
      #1;
      chk("br_ctl", ctl(), {24'd0, 2'b01, 3'b000, 2'b11, 1'b0});
      step(); idle_inputs(); #1;
      chk("br_fcnt", {28'd0, hz.FlushCount}, 32'd2);

      // Load-use on rs2.
      set_lw();
      #1;
      chk("lw_ctl", ctl(), {24'd0, 2'b00, 3'b110, 2'b01, 1'b0});
      step(); idle_inputs(); #1;
      chk("lw_scnt", {28'd0, hz.StallCount}, 32'd1);
      chk("lw_clear", ctl(), 32'h0);
      // Load to x0 never stalls; rs1 match with UsesRs1D=0 also does not.
      hz.MemReadE = 1; hz.RdE = 5'd0; hz.Rs2D = 5'd0; hz.UsesRs2D = 1;
      #1;
      chk("lw_x0", {31'd0, hz.StallF}, 32'd0);
      hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.UsesRs1D = 0; hz.Rs2D = 5'd1;
      #1;
      chk("lw_nouse", {31'd0, hz.StallF}, 32'd0);
      step(); idle_inputs(); #1;
      chk("lw_x0_scnt", {28'd0, hz.StallCount}, 32'd1);

      // Divide, DIV_CYCLES=4: four stalled cycles then a DONE pulse.
      do_reset();
      hz.DivStartE = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("div_stall%0d", i), ctl(), {24'd0, 2'b00, 3'b111, 2'b00, 1'b0});
         chk($sformatf("div_busy%0d", i), {31'd0, hz.DivBusy}, (i == 0) ? 32'd0 : 32'd1);
         step();
      end
      chk("div_done", ctl(), {24'd0, 2'b00, 3'b000, 2'b00, 1'b1});
      chk("div_done_busy", {31'd0, hz.DivBusy}, 32'd1);
      step(); hz.DivStartE = 0; #1;
      chk("div_after_busy", {31'd0, hz.DivBusy}, 32'd0);
      chk("div_after_ctl", ctl(), 32'h0);
      chk("div_scnt", {28'd0, hz.StallCount}, 32'd4);

      // Divide start colliding with a redirect: redirect wins, no divide.
      hz.DivStartE = 1; hz.PCSrcE = 1;
      #1;
      chk("div_vs_redir", ctl(), {24'd0, 2'b01, 3'b000, 2'b11, 1'b0});
      step(); idle_inputs(); #1;
      chk("div_vs_redir_busy", {31'd0, hz.DivBusy}, 32'd0);

      // Hazards during BUSY are masked; reset mid-divide aborts.
      hz.DivStartE = 1;
      step();
      hz.PCSrcE = 1; hz.JumpE = 1; hz.is_jalr_E = 1; set_lw();
      #1;
      chk("busy_mask", ctl(), {24'd0, 2'b00, 3'b111, 2'b00, 1'b0});
      step();
      chk("busy2", {31'd0, hz.DivBusy}, 32'd1);
      rst = 0;
      #1;
      chk("abort_busy", {31'd0, hz.DivBusy}, 32'd0);
      chk("abort_ctl", ctl(), 32'h0);
      idle_inputs();
      #1 rst = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("abort_nodone%0d", i), {30'd0, hz.DivDoneE, hz.DivBusy}, 32'd0);
      end

      // Saturation of the 4-bit stall counter.
      do_reset();
      set_lw();
      for (int i = 0; i < 14; i++) step();
      chk("sat_14", {28'd0, hz.StallCount}, 32'd14);
      for (int i = 0; i < 6; i++) step();
      chk("sat_15", {28'd0, hz.StallCount}, 32'd15);
      idle_inputs();
      step();
      chk("sat_hold", {28'd0, hz.StallCount}, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fetch_hazard_ctrl.md
Name: fetch_hazard_ctrl

Overview:
Pipeline sequencing controller for the fetch and decode front end of the RV32IM 5-stage core. Generates PC-next select, stall and flush controls for the PC, IF/ID and ID/EX registers. Covers Execute-stage redirects (branch/JAL/JALR), load-use hazards and multi-cycle M-extension divide occupancy of Execute. Keeps saturating performance counters for stall and flush events.

Parameters:
DIV_CYCLES, 32, cycles a DIV/DIVU/REM/REMU holds Execute; legal range 2..65535
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets the block)
MemReadE  in  1  instruction in Execute is a load
RdE  in  5  destination register of the Execute instruction
Rs1D  in  5  rs1 of the Decode instruction
Rs2D  in  5  rs2 of the Decode instruction
UsesRs1D  in  1  Decode instruction reads rs1
UsesRs2D  in  1  Decode instruction reads rs2
PCSrcE  in  1  branch taken or JAL in Execute
JumpE  in  1  jump in Execute
is_jalr_E  in  1  Execute jump is JALR
DivStartE  in  1  divide/remainder op valid in Execute
PCSelF  out  2  00=PC+4, 01=PCTargetE, 10=JALR_TargetE
StallF  out  1  hold the PC
StallD  out  1  hold the IF/ID register
StallE  out  1  hold the ID/EX register and Execute operands
FlushD  out  1  load NOP 0x00000013 into IF/ID
FlushE  out  1  load bubble into ID/EX
DivBusy  out  1  divide FSM not IDLE
DivDoneE  out  1  one-cycle pulse: divide result valid in Execute this cycle
StallCount  out  CNT_W  cycles with StallF=1, saturating
FlushCount  out  CNT_W  cycles with FlushD=1, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE, divide counter=0, StallCount=0, FlushCount=0. All outputs forced to 0 while rst=0, including PCSelF=00 and combinational outputs.
- redirect = PCSrcE | (JumpE & is_jalr_E).
- PCSelF priority: (JumpE & is_jalr_E) gives 10, else PCSrcE gives 01, else 00.
- lwStall = MemReadE & (RdE!=0) & ((UsesRs1D & Rs1D==RdE) | (UsesRs2D & Rs2D==RdE)).
- Divide FSM states IDLE, BUSY, DONE:
  - IDLE→BUSY when DivStartE & !redirect. Counter loads DIV_CYCLES-2.
  - BUSY: counter decrements each cycle. BUSY→DONE when the counter is 0.
  - DONE→IDLE always. DivDoneE=1 only in DONE. DivStartE is ignored in DONE, because the same op is still in Execute.
  - divStall = (IDLE & DivStartE & !redirect) | BUSY. Execute is held for exactly DIV_CYCLES cycles, then DONE lets it advance.
- Output resolution, highest priority first:
  - divStall: StallF=StallD=StallE=1, FlushD=FlushE=0, PCSelF=00. A redirect or lwStall in the same cycle is ignored.
  - redirect: FlushD=FlushE=1, stalls=0.
  - lwStall: StallF=StallD=1, FlushE=1, StallE=0.
  - Otherwise all controls are 0.
- DivStartE together with redirect in IDLE is a protocol violation. Redirect wins and no divide starts.
- lwStall lasts one cycle per occurrence. The load advances and the bubble resolves the hazard, with forwarding handled elsewhere.
- Counters increment on the rising edge when their condition holds and hold at 2^CNT_W-1.
- Reset asserted mid-divide aborts the operation. The FSM returns to IDLE immediately, and after release no DivDoneE pulse occurs for the aborted op.
- DivBusy = (state != IDLE).

Test Plan:
- Reset: rst=0 with PCSrcE=1 and MemReadE=1 driven → all outputs 0. After rst=1 with idle inputs → PCSelF=00, counters 0.
- JALR: JumpE=1, is_jalr_E=1, PCSrcE=1 → PCSelF=10, FlushD=FlushE=1, StallF=0. FlushCount goes 0→1 on the next edge.
- Load-use: MemReadE=1, RdE=5, Rs2D=5, UsesRs2D=1 for 1 cycle → StallF=StallD=FlushE=1 for 1 cycle, StallCount=1. Repeat with RdE=0 → no stall.
- Divide with DIV_CYCLES=4: pulse DivStartE held steady → StallE=1 for exactly 4 cycles, then DivDoneE=1 for 1 cycle, then DivBusy=0, StallCount=4.
- Divide plus hazards: during BUSY drive PCSrcE=1 and lwStall → no flush, PCSelF=00, stalls still 1. Assert rst=0 at cycle 2 of BUSY → DivBusy=0 at once and no DivDoneE afterwards.
- Saturation with CNT_W=4: hold lwStall 20 cycles → StallCount stops at 15.
